// File: rtl/i2s_stereo_receiver.sv
// I2S stereo receiver: synchronises the codec pins, aligns to word-select frames and
// presents sign-extended left/right sample pairs with a one-cycle valid strobe.
module i2s_stereo_receiver #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SAMPLE_BITS = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  error_clear,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_sdata,
  output logic [DATA_WIDTH-1:0] left_audio_out,
  output logic [DATA_WIDTH-1:0] right_audio_out,
  output logic                  sample_valid,
  output logic                  frame_error,
  output logic [5:0]            debug_bit_count
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_BITS);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, lr_sync_q, sd_sync_q;
  logic                   bclk_prev_q, lr_prev_q;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] left_hold_q, left_hold_d;
  logic [CNT_W-1:0]       bit_count_q, bit_count_d;
  logic                   slot_lr_q, slot_lr_d;
  logic                   left_valid_q, left_valid_d;
  logic [DATA_WIDTH-1:0]  left_q, left_d, right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;
  logic [CNT_W-1:0]       debug_q, debug_d;
  logic                   err_set;

  logic bclk_s, lr_s, sd_s, tick, trans, slot_full;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lr_s      = lr_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign tick      = bclk_s & ~bclk_prev_q;
  assign trans     = tick & (lr_s != lr_prev_q);
  assign slot_full = (bit_count_q == FULL_CNT);

  // Pin synchronisers and bit-tick edge tracking; these run regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
      lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata};
      bclk_prev_q <= bclk_s;
      if (tick) lr_prev_q <= lr_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a full slot parks in WAIT until the next word-select transition.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (trans && !lr_s) state_d = ST_SHIFT;
        ST_SHIFT: if (slot_full)      state_d = ST_WAIT;
        ST_WAIT:  if (trans)          state_d = ST_SHIFT;
        default:                      state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: capture, short-slot detection and pair presentation.
  always_comb begin
    shift_d      = shift_q;
    bit_count_d  = bit_count_q;
    slot_lr_d    = slot_lr_q;
    left_hold_d  = left_hold_q;
    left_valid_d = left_valid_q;
    left_d       = left_q;
    right_d      = right_q;
    valid_d      = 1'b0;
    err_set      = 1'b0;
    if (!enable) begin
      shift_d      = '0;
      bit_count_d  = '0;
      left_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trans && !lr_s) begin
            shift_d     = '0;
            bit_count_d = '0;
            slot_lr_d   = 1'b0;
          end
        end
        ST_SHIFT: begin
          if (slot_full) begin
            if (!slot_lr_q) begin
              left_hold_d  = shift_q;
              left_valid_d = 1'b1;
            end else if (left_valid_q) begin
              left_d       = DATA_WIDTH'($signed(left_hold_q));
              right_d      = DATA_WIDTH'($signed(shift_q));
              valid_d      = 1'b1;
              left_valid_d = 1'b0;
            end
          end else if (trans) begin
            // Slot ended early: drop the partial word but capture the new slot.
            err_set      = 1'b1;
            shift_d      = '0;
            bit_count_d  = '0;
            left_valid_d = 1'b0;
            slot_lr_d    = lr_s;
          end else if (tick) begin
            shift_d     = {shift_q[SAMPLE_BITS-2:0], sd_s};
            bit_count_d = bit_count_q + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (trans) begin
            shift_d     = '0;
            bit_count_d = '0;
            slot_lr_d   = lr_s;
          end
        end
        default: ;
      endcase
    end
    error_d = err_set ? 1'b1 : (error_clear ? 1'b0 : error_q);
    debug_d = (state_d == ST_IDLE) ? '0 : bit_count_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      bit_count_q  <= '0;
      slot_lr_q    <= 1'b0;
      left_hold_q  <= '0;
      left_valid_q <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      debug_q      <= '0;
    end else begin
      shift_q      <= shift_d;
      bit_count_q  <= bit_count_d;
      slot_lr_q    <= slot_lr_d;
      left_hold_q  <= left_hold_d;
      left_valid_q <= left_valid_d;
      left_q       <= left_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      debug_q      <= debug_d;
    end
  end

  assign left_audio_out  = left_q;
  assign right_audio_out = right_q;
  assign sample_valid    = valid_q;
  assign frame_error     = error_q;
  assign debug_bit_count = debug_q;

endmodule

// File: doc/i2s_stereo_receiver.md
Name: i2s_stereo_receiver

Overview:
Deserialises an I2S audio stream from the codec ADC into parallel signed stereo samples for the stereo filter stage directly downstream. The block synchronises the codec bit clock, word-select and data pins into the system clock domain, then aligns to frames on word-select transitions. It captures SAMPLE_BITS MSB-first bits per channel and presents a sign-extended left/right pair with a one-cycle valid strobe. It also flags malformed frames.

Parameters:
DATA_WIDTH, 32, width of each parallel output sample.
SAMPLE_BITS, 24, bits captured per channel slot; legal range 8..DATA_WIDTH.
SYNC_STAGES, 2, flip-flop stages on each asynchronous I2S input; minimum 2.

Ports:
clk  input  1  system clock; must be at least 4x i2s_bclk.
reset  input  1  asynchronous, active-low reset.
enable  input  1  receiver run control (SW[0]).
error_clear  input  1  synchronous clear of frame_error.
i2s_bclk  input  1  codec bit clock, asynchronous to clk.
i2s_lrclk  input  1  word select, asynchronous; 0 = left, 1 = right.
i2s_sdata  input  1  serial data, asynchronous.
left_audio_out  output  DATA_WIDTH  signed left sample.
right_audio_out  output  DATA_WIDTH  signed right sample.
sample_valid  output  1  one-clk pulse when a new stereo pair is presented.
frame_error  output  1  sticky: a channel slot ended before SAMPLE_BITS bits were received.
debug_bit_count  output  6  bit index inside the current slot.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, synchronisers 0, state IDLE, hold registers and shift register 0.
- Synchronisation: bclk, lrclk and sdata each pass through SYNC_STAGES flops. A rising edge of bclk is detected as sync=1 with previous sync=0. At each detected edge (a "bit tick"), lrclk and sdata are sampled together.
- Transition tick: a bit tick where sampled lrclk differs from the lrclk sampled at the previous tick. Its data bit is the I2S delay bit and is discarded. The next tick carries the MSB.
- States:
  - IDLE: wait for a transition tick to 0 (start of left), then go to SHIFT with bit_count=0. Right slots seen in IDLE are ignored.
  - SHIFT: on each non-transition tick, shift sdata into the LSB and increment bit_count. When bit_count reaches SAMPLE_BITS, latch into left_hold or right_hold according to the slot's lrclk, then go to WAIT.
  - WAIT: ignore ticks (surplus slot bits) until a transition tick, then go to SHIFT with bit_count=0.
- Short slot: a transition tick while in SHIFT with bit_count < SAMPLE_BITS sets frame_error, discards the partial word and clears left_valid_flag. The new slot is still captured.
- Pair output:
  - On right latch with left_valid_flag=1: load both outputs simultaneously in the same cycle, pulse sample_valid for exactly 1 clk, and clear left_valid_flag.
  - A right word without a preceding complete left word produces no output.
- Width rule: each output is the SAMPLE_BITS word sign-extended to DATA_WIDTH.
- Latency: sample_valid rises SYNC_STAGES+2 clk cycles after the pin-level bclk rising edge carrying the final right bit.
- frame_error: set has priority over error_clear in the same cycle; otherwise error_clear=1 clears it.
- enable=0: go to IDLE, clear the shift register, bit_count and left_valid_flag. Outputs hold their last values, sample_valid=0, and frame_error holds. Synchronisers keep running, so re-enabling realigns on the next left transition.
- debug_bit_count: equals bit_count in SHIFT, holds SAMPLE_BITS in WAIT, and reads 0 in IDLE.

Test Plan:
- Nominal frame (SAMPLE_BITS=24, bclk=clk/8, 32-bit slots): left 0x7FFFFF, right 0x800000 -> left_audio_out=0x007FFFFF and right_audio_out=0xFF800000, one sample_valid pulse at SYNC_STAGES+2 clks after the last right bit edge, frame_error=0.
- Streaming: 8 frames of a ramp (left=n, right=-n) -> exactly 8 pulses with matching values and none lost. Surplus 8 bits per slot are ignored.
- Mid-frame start: release reset during a right slot -> no output until the first full left+right pair, then the correct pair.
- Short slot: left slot of 16 bclks -> frame_error=1, no pulse for that frame, next good frame outputs correctly. error_clear pulse -> frame_error=0.
- enable dropped mid-left-slot for 100 clks, then raised -> outputs keep prior pair, no spurious pulse, next full frame captured correctly.
- Asynchronous reset asserted mid-SHIFT -> outputs 0 immediately (no clk edge needed), sample_valid=0, debug_bit_count=0.
